// File: rtl/hdmi_video_timing.sv
// Raster timing generator for a DVI/HDMI TMDS transmitter: issues pixel requests to a
// fixed-latency pixel source and delays DE/sync/start flags to meet the returning RGB.
module hdmi_video_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIX_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic        enable,
  input  logic [23:0] rgb_in,
  output logic        req_valid,
  output logic [11:0] req_x,
  output logic [11:0] req_y,
  output logic [7:0]  vd_r,
  output logic [7:0]  vd_g,
  output logic [7:0]  vd_b,
  output logic        vde,
  output logic [1:0]  cd,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DEPTH   = PIX_LATENCY + 1;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic fs;
    logic ls;
    logic vs;
    logic hs;
    logic de;
  } flags_t;

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  flags_t      raw;
  flags_t      flags_p [DEPTH];
  flags_t      tap;

  // Flags are active-high "asserted" bits; polarity is applied only at the output.
  always_comb begin
    raw = '0;
    if (enable) begin
      raw.de = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      raw.hs = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      raw.vs = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      raw.ls = raw.de && (h_cnt == 12'd0);
      raw.fs = raw.ls && (v_cnt == 12'd0);
    end
  end

  // Request stage: counters and pixel request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      req_valid <= 1'b0;
      req_x     <= '0;
      req_y     <= '0;
    end else if (pix_ce) begin
      req_valid <= raw.de;
      req_x     <= raw.de ? h_cnt : '0;
      req_y     <= raw.de ? v_cnt : '0;
      if (!enable) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  // Delay stages: flags_p[0] aligns with the request, flags_p[DEPTH-1] with rgb_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) flags_p[i] <= '0;
    end else if (pix_ce) begin
      flags_p[0] <= raw;
      for (int i = 1; i < DEPTH; i++) flags_p[i] <= flags_p[i-1];
    end
  end

  assign tap = flags_p[DEPTH-1];

  // Output stage: registered encoder inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vde         <= 1'b0;
      vd_r        <= 8'h00;
      vd_g        <= 8'h00;
      vd_b        <= 8'h00;
      cd          <= {~VSYNC_POL, ~HSYNC_POL};
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      vde         <= tap.de;
      vd_r        <= tap.de ? rgb_in[23:16] : 8'h00;
      vd_g        <= tap.de ? rgb_in[15:8]  : 8'h00;
      vd_b        <= tap.de ? rgb_in[7:0]   : 8'h00;
      cd          <= {tap.vs ? VSYNC_POL : ~VSYNC_POL, tap.hs ? HSYNC_POL : ~HSYNC_POL};
      line_start  <= tap.ls;
      frame_start <= tap.fs;
    end
  end

endmodule

// File: doc/hdmi_video_timing.md
HDMI_VIDEO_TIMING -- requirements
Module: hdmi_video_timing

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
  H_ACTIVE 640 visible pixels per line
  H_FP 16 horizontal front porch
  H_SYNC 96 hsync width
  H_BP 48 horizontal back porch
  V_ACTIVE 480 visible lines
  V_FP 10 vertical front porch
  V_SYNC 2 vsync width
  V_BP 33 vertical back porch
  HSYNC_POL 0 active hsync level
  VSYNC_POL 0 active vsync level
  PIX_LATENCY 2 pix_ce ticks from request to rgb_in valid, 1..8
REQ-002 Ports SHALL be (name direction width meaning), one per line:
  clk input 1 single clock; the only clock
  rst_n input 1 reset, asynchronous, active-low
  pix_ce input 1 pixel tick; all state advances only when high
  enable input 1 run timing; low parks counters
  rgb_in input 24 {R,G,B} from pixel source, PIX_LATENCY ticks after request
  req_valid output 1 pixel request, current position is active
  req_x output 12 requested column
  req_y output 12 requested row
  vd_r, vd_g, vd_b output 8 each, video data to the three TMDS encoders
  vde output 1 video data enable to encoders
  cd output 2 control data {vsync,hsync} to channel-0 encoder
  line_start output 1 one-tick pulse, first active pixel of a line at the output
  frame_start output 1 one-tick pulse, pixel (0,0) at the output

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise; counters h_cnt, v_cnt SHALL be 12 bits.
REQ-004 On each pix_ce with enable high, h_cnt SHALL increment, wrap H_TOTAL-1 -> 0, and v_cnt SHALL increment on that wrap, wrapping V_TOTAL-1 -> 0.
REQ-005 Without pix_ce, every register in the block (counters, delay line, outputs) SHALL hold.
REQ-006 req_valid, req_x, req_y SHALL be registered: valid = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE), x=h_cnt, y=v_cnt; x/y SHALL read 0 when not valid.
REQ-007 Raw hsync active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vsync active iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines); driven levels SHALL be POL when active, ~POL otherwise.
REQ-008 Raw de, hsync, vsync, line/frame-start flags SHALL pass through a PIX_LATENCY-deep pix_ce-gated delay line so that vde/cd/pulses align with rgb_in for the same pixel.
REQ-009 On the output tick: vde = delayed de; vd_* = rgb_in fields when delayed de, else 8'h00; cd = delayed {vsync,hsync}; all registered.
REQ-010 Total latency from req_valid rise to vde rise SHALL be exactly PIX_LATENCY+1 pix_ce ticks.
REQ-011 enable low at a pix_ce tick SHALL force h_cnt=v_cnt=0 and req_valid=0; the delay line SHALL keep shifting, injecting de=0 and inactive sync levels.
REQ-012 enable rising SHALL start at (0,0) on the first enabled tick; frame_start SHALL then pulse PIX_LATENCY+1 ticks later.
REQ-013 line_start/frame_start SHALL be high for exactly one pix_ce tick and remain asserted until the next pix_ce (pulse width measured in ticks).
REQ-014 Parameter values with any porch/sync of 0 SHALL be legal; vsync/hsync simultaneously active SHALL yield both cd bits active.

Reset
REQ-015 rst_n low SHALL immediately clear counters, delay line, req_valid, req_x, req_y, vde, vd_*, line_start, frame_start to 0 and set cd = {~VSYNC_POL,~HSYNC_POL}; no frame_start SHALL issue until first enabled tick after release.
REQ-016 Reset asserted mid-frame SHALL abort the frame; restart is at (0,0) per REQ-012.

Verification
REQ-017 Params H 4/1/2/1, V 2/1/1/1, latency 2, pix_ce=1: req_valid high 4 of 8 ticks per line for v=0,1; vde first high 3 ticks after first req_valid; frame_start period 40 ticks.
REQ-018 Same: hsync (POL 0) cd[0]=0 at h_cnt 5,6 only; cd[1]=0 for all of v_cnt=3; cd=2'b11 during blanking elsewhere.
REQ-019 rgb_in driven = {x,y,8'hA5} delayed 2 ticks: vd_r/vd_g match request coordinates for every active pixel, 0 when vde=0.
REQ-020 pix_ce toggling 1-of-4 cycles: outputs change only in pix_ce cycles; frame period 160 clk.
REQ-021 rst_n pulsed low mid-line at (2,1): outputs at reset values asynchronously; after release with enable high, first req at (0,0), frame_start 3 ticks later.
REQ-022 enable low for 10 ticks mid-frame: req_valid 0, vde 0 within 3 ticks, cd inactive; re-enable restarts at (0,0).
